// File: rtl/midi_pkg.sv
// midi_pkg: MIDI status constants, FSM state types and message sizing helpers
package midi_pkg;

    localparam logic [3:0] NOTE_OFF         = 4'h8;
    localparam logic [3:0] NOTE_ON          = 4'h9;
    localparam logic [3:0] POLY_PRESSURE    = 4'hA;
    localparam logic [3:0] CONTROL_CHANGE   = 4'hB;
    localparam logic [3:0] PROGRAM_CHANGE   = 4'hC;
    localparam logic [3:0] CHANNEL_PRESSURE = 4'hD;
    localparam logic [3:0] PITCH_BEND       = 4'hE;
    localparam logic [3:0] SYSTEM           = 4'hF;

    typedef enum logic {IDLE, SEND} msg_state_e;
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_e;

    // total bytes in a message, status byte included
    function automatic logic [1:0] msg_len(input logic [7:0] status);
        case (status[7:4])
            NOTE_OFF, NOTE_ON, POLY_PRESSURE, CONTROL_CHANGE, PITCH_BEND: return 2'd3;
            PROGRAM_CHANGE, CHANNEL_PRESSURE: return 2'd2;
            SYSTEM: return status == 8'hF2 ? 2'd3 :
                           (status == 8'hF1 || status == 8'hF3) ? 2'd2 : 2'd1;
            default: return 2'd1;
        endcase
    endfunction

    // 0x80..0xEF: the only statuses eligible for running status
    function automatic logic is_channel_voice(input logic [7:0] status);
        return status[7] && status[7:4] != SYSTEM;
    endfunction

endpackage

// File: rtl/midi_uart_tx.sv
// midi_uart_tx: 8N1 serialiser that takes its next byte in the last stop-bit cycle
module midi_uart_tx
    import midi_pkg::*;
#(
    parameter int BAUD_DIV = 3200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       byte_valid,
    output logic       byte_ready,
    input  logic [7:0] byte_data,
    output logic       frame_end,
    output logic       tx
);

    localparam int BW = $clog2(BAUD_DIV);
    localparam logic [BW-1:0] LAST = BW'(BAUD_DIV - 1);

    uart_state_e state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] shift_q, shift_d;
    logic tx_q, tx_d;
    logic tick, take;

    assign tick       = baud_q == LAST;
    assign frame_end  = state_q == S_STOP && tick;
    assign byte_ready = state_q == S_IDLE || frame_end;
    assign take       = byte_valid && byte_ready;
    assign tx         = tx_q;

    // advance one bit per baud period; a handshake always restarts at a start bit
    always_comb begin
        state_d = state_q;
        baud_d  = (state_q == S_IDLE || tick) ? '0 : baud_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        if (take) begin
            state_d = S_START;
            baud_d  = '0;
            shift_d = byte_data;
            tx_d    = 1'b0;
        end else if (tick) begin
            case (state_q)
                S_START: begin
                    state_d = S_DATA;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                end
                S_DATA: begin
                    state_d = bit_q == 3'd7 ? S_STOP : S_DATA;
                    bit_d   = bit_q + 3'd1;
                    shift_d = shift_q >> 1;
                    tx_d    = bit_q == 3'd7 ? 1'b1 : shift_q[1];
                end
                S_STOP:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // line idles high and snaps high on reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

endmodule

// File: rtl/midi_msg_tx.sv
// midi_msg_tx: sizes a MIDI message, applies running status and feeds the serialiser
module midi_msg_tx
    import midi_pkg::*;
#(
    parameter int BAUD_DIV       = 3200,
    parameter bit RUNNING_STATUS = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       msg_valid,
    output logic       msg_ready,
    input  logic [7:0] msg_status,
    input  logic [6:0] msg_data1,
    input  logic [6:0] msg_data2,
    output logic       busy,
    output logic       led,
    output logic       midi_tx,
    output logic       err_status
);

    msg_state_e state_q, state_d;
    logic [7:0] last_q, last_d, b1_q, b1_d, b2_q, b2_d;
    logic [1:0] rem_q, rem_d;
    logic err_q, err_d;
    logic accept, good, skip, u_valid, u_ready, u_end;
    logic [1:0] n_send;
    logic [7:0] d1, d2, first, u_byte;

    assign msg_ready  = state_q == IDLE;
    assign busy       = state_q == SEND;
    assign led        = busy;
    assign err_status = err_q;
    assign accept     = msg_valid && msg_ready;
    assign good       = msg_status[7];
    assign d1         = {1'b0, msg_data1};
    assign d2         = {1'b0, msg_data2};
    assign skip       = RUNNING_STATUS && is_channel_voice(msg_status) && msg_status == last_q;
    assign n_send     = msg_len(msg_status) - {1'b0, skip};
    assign first      = skip ? d1 : msg_status;
    // the first byte goes straight from the inputs so the start bit follows the accept edge
    assign u_valid    = msg_ready ? accept && good : rem_q != 2'd0;
    assign u_byte     = msg_ready ? first : b1_q;

    midi_uart_tx #(.BAUD_DIV(BAUD_DIV)) u_uart (
        .clk       (clk),
        .rst       (rst),
        .byte_valid(u_valid),
        .byte_ready(u_ready),
        .byte_data (u_byte),
        .frame_end (u_end),
        .tx        (midi_tx)
    );

    // accept/reject messages, queue the remaining bytes and track running status
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        b1_d    = b1_q;
        b2_d    = b2_q;
        rem_d   = rem_q;
        err_d   = 1'b0;
        if (accept) begin
            err_d = !good;
            if (good) begin
                state_d = SEND;
                b1_d    = skip ? d2 : d1;
                b2_d    = d2;
                rem_d   = n_send - 2'd1;
                last_d  = is_channel_voice(msg_status) ? msg_status :
                          msg_status[3] ? last_q : 8'h00;
            end
        end else if (state_q == SEND) begin
            if (u_valid && u_ready) begin
                b1_d  = b2_q;
                rem_d = rem_q - 2'd1;
            end else if (u_end) begin
                state_d = IDLE;
            end
        end
    end

    // reset discards any partial message and forgets running status
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            last_q  <= 8'h00;
            b1_q    <= 8'h00;
            b2_q    <= 8'h00;
            rem_q   <= 2'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            b1_q    <= b1_d;
            b2_q    <= b2_d;
            rem_q   <= rem_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_midi_msg_tx.sv
// tb_midi_msg_tx: scoreboard bench decoding the MIDI line of a running-status and a plain instance
module tb_midi_msg_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] valid = 2'b00;
    logic [7:0] st = 8'h00;
    logic [6:0] d1 = 7'h00;
    logic [6:0] d2 = 7'h00;
    logic [1:0] ready, busy, led, tx, err;

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    int bq0[$];
    int bq1[$];

    always #5 clk = ~clk;

    midi_msg_tx #(.BAUD_DIV(4), .RUNNING_STATUS(1'b1)) dut_rs (
        .clk(clk), .rst(rst), .msg_valid(valid[0]), .msg_ready(ready[0]),
        .msg_status(st), .msg_data1(d1), .msg_data2(d2),
        .busy(busy[0]), .led(led[0]), .midi_tx(tx[0]), .err_status(err[0])
    );

    midi_msg_tx #(.BAUD_DIV(4), .RUNNING_STATUS(1'b0)) dut_plain (
        .clk(clk), .rst(rst), .msg_valid(valid[1]), .msg_ready(ready[1]),
        .msg_status(st), .msg_data1(d1), .msg_data2(d2),
        .busy(busy[1]), .led(led[1]), .midi_tx(tx[1]), .err_status(err[1])
    );

    task automatic check(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // monitor: decode each line 8N1 (samples mid-bit) and measure busy periods
    logic [1:0] act = 2'b00;
    int cnt[2];
    int bcnt[2] = '{0, 0};
    logic [9:0] frm[2];
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst) begin
                act[i] = 1'b0;
                bcnt[i] = 0;
            end else begin
                if (busy[i]) bcnt[i]++;
                else if (bcnt[i] > 0) begin
                    if ((i == 0 ? bq0.size() : bq1.size()) == 0) check("unexpected busy period", bcnt[i], 0);
                    else check("busy cycles", bcnt[i], i == 0 ? bq0.pop_front() : bq1.pop_front());
                    check("ready after message", int'(ready[i]), 1);
                    check("led follows busy", int'(led[i]), 0);
                    bcnt[i] = 0;
                end
                if (!act[i] && !tx[i]) begin
                    act[i] = 1'b1;
                    cnt[i] = 0;
                end
                if (act[i]) begin
                    if (cnt[i] % 4 == 2) frm[i][cnt[i] / 4] = tx[i];
                    if (cnt[i] == 39) begin
                        act[i] = 1'b0;
                        if ((i == 0 ? q0.size() : q1.size()) == 0) check("unexpected byte", int'(frm[i]), -1);
                        else check("frame {stop,byte,start}", int'(frm[i]),
                                   int'({1'b1, (i == 0 ? q0.pop_front() : q1.pop_front()), 1'b0}));
                    end
                    cnt[i]++;
                end
            end
        end
    end

    task automatic expect_msg(input int s, input int cyc, input int n,
                              input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        logic [7:0] b[3];
        b = '{b0, b1, b2};
        for (int k = 0; k < n; k++) begin
            if (s == 0) q0.push_back(b[k]);
            else q1.push_back(b[k]);
        end
        if (s == 0) bq0.push_back(cyc);
        else bq1.push_back(cyc);
    endtask

    task automatic send(input int s, input logic [7:0] status, input logic [6:0] a, input logic [6:0] c);
        int n = 0;
        @(negedge clk);
        while (ready[s] !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) check("ready timeout", int'(ready[s]), 1);
        st = status;
        d1 = a;
        d2 = c;
        valid[s] = 1'b1;
        @(posedge clk);
        #1 valid[s] = 1'b0;
    endtask

    initial begin
        int bad = 0;
        int n = 0;
        #12;
        check("reset midi_tx", int'(tx[0]), 1);
        check("reset msg_ready", int'(ready[0]), 1);
        check("reset busy", int'(busy[0]), 0);
        check("reset led", int'(led[0]), 0);
        check("reset err_status", int'(err[0]), 0);
        check("reset midi_tx plain", int'(tx[1]), 1);
        @(negedge clk);
        rst = 1'b1;
        repeat (50) begin
            @(negedge clk);
            if (tx[0] !== 1'b1 || ready[0] !== 1'b1 || busy[0] !== 1'b0) bad++;
        end
        check("idle 50 cycles", bad, 0);

        expect_msg(0, 120, 3, 8'h90, 8'h3C, 8'h64);
        send(0, 8'h90, 7'h3C, 7'h64);
        check("start bit after accept", int'(tx[0]), 0);
        check("busy after accept", int'(busy[0]), 1);
        check("ready low after accept", int'(ready[0]), 0);
        expect_msg(0, 80, 2, 8'h40, 8'h00, 8'h00);
        send(0, 8'h90, 7'h40, 7'h00);
        expect_msg(0, 80, 2, 8'hC5, 8'h07, 8'h00);
        send(0, 8'hC5, 7'h07, 7'h55);
        expect_msg(0, 40, 1, 8'hF8, 8'h00, 8'h00);
        send(0, 8'hF8, 7'h11, 7'h22);
        expect_msg(0, 40, 1, 8'h07, 8'h00, 8'h00);
        send(0, 8'hC5, 7'h07, 7'h00);
        expect_msg(0, 120, 3, 8'hF2, 8'h01, 8'h02);
        send(0, 8'hF2, 7'h01, 7'h02);
        expect_msg(0, 80, 2, 8'hC5, 8'h07, 8'h00);
        send(0, 8'hC5, 7'h07, 7'h00);

        send(0, 8'h45, 7'h01, 7'h02);
        check("err_status pulse", int'(err[0]), 1);
        check("ready during err", int'(ready[0]), 1);
        check("line idle on err", int'(tx[0]), 1);
        @(posedge clk);
        #1;
        check("err_status one cycle", int'(err[0]), 0);
        check("ready after err", int'(ready[0]), 1);
        expect_msg(0, 120, 3, 8'h91, 8'h11, 8'h22);
        send(0, 8'h91, 7'h11, 7'h22);

        q0.push_back(8'h90);
        q0.push_back(8'h3C);
        q0.push_back(8'h64);
        send(0, 8'h90, 7'h3C, 7'h64);
        repeat (45) @(posedge clk);
        #2;
        check("line low in byte 2 bit 0", int'(tx[0]), 0);
        rst = 1'b0;
        #1;
        check("line high on reset", int'(tx[0]), 1);
        check("ready on reset", int'(ready[0]), 1);
        check("busy cleared on reset", int'(busy[0]), 0);
        check("bytes left at reset", q0.size(), 2);
        q0.delete();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        expect_msg(0, 120, 3, 8'h90, 8'h3C, 8'h64);
        send(0, 8'h90, 7'h3C, 7'h64);

        expect_msg(1, 120, 3, 8'h90, 8'h3C, 8'h64);
        send(1, 8'h90, 7'h3C, 7'h64);
        expect_msg(1, 120, 3, 8'h90, 8'h40, 8'h00);
        send(1, 8'h90, 7'h40, 7'h00);

        while ((q0.size() + q1.size() + bq0.size() + bq1.size()) != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(negedge clk);
        check("bytes outstanding", q0.size() + q1.size(), 0);
        check("busy periods outstanding", bq0.size() + bq1.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/midi_msg_tx.md
# midi_msg_tx

Parametrised MIDI message transmitter. Accepts one complete MIDI message (status plus up to two data bytes) per valid/ready handshake and serialises it on the 31250-baud MIDI OUT line with correct UART framing: idle high, start bit low, 8 data bits LSB first, stop bit high. It sizes the message from the status byte and optionally applies running status. It sits between the control logic (button/sequencer) and the MIDI OUT pin.

## Interface
- BAUD_DIV, 3200, clk cycles per bit (100 MHz / 31250); must be ≥ 2
- RUNNING_STATUS, 1, 1 = omit a repeated channel-voice status byte; 0 = always send status

- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- msg_valid  in  1  message offered
- msg_ready  out  1  block can accept a message
- msg_status  in  8  status byte
- msg_data1  in  7  first data byte (bit 7 sent as 0)
- msg_data2  in  7  second data byte (bit 7 sent as 0)
- busy  out  1  high from acceptance until the last stop bit ends
- led  out  1  activity indicator, equal to busy
- midi_tx  out  1  serial MIDI line, idle high
- err_status  out  1  one-cycle pulse: offered status has bit 7 = 0; message dropped

## Operation
- Accept on `msg_valid && msg_ready`. Latch all three inputs. `msg_ready = (state == IDLE)`.
- If `msg_status[7] == 0`:
  - pulse `err_status`
  - drop the message; consume the handshake
  - send nothing; stay in IDLE
- Length from status (total bytes including status):
  - 0x8_, 0x9_, 0xA_, 0xB_, 0xE_ → 3
  - 0xC_, 0xD_ → 2
  - 0xF2 → 3
  - 0xF1, 0xF3 → 2
  - all other 0xF_ → 1
- Running status (RUNNING_STATUS = 1):
  - `last_status` register, reset 0x00.
  - Channel-voice status (0x80–0xEF) equal to `last_status` → status byte skipped; only data bytes sent.
  - Channel-voice status not equal to `last_status` → sent, and loaded into `last_status`.
  - 0xF0–0xF7 → sent and clears `last_status` to 0x00.
  - 0xF8–0xFF (real-time) → sent; `last_status` unchanged.
- Top FSM:
  - IDLE → SEND on a valid accept.
  - SEND issues bytes in order (status?, data1?, data2?) to the serialiser.
  - SEND → IDLE when the last byte's stop bit completes.
- Serialiser FSM: S_IDLE → S_START → S_DATA (8 bits, LSB first) → S_STOP → S_IDLE, or directly S_START if another byte is pending.
- Baud counter:
  - counts 0..BAUD_DIV−1, width `$clog2(BAUD_DIV)`
  - cleared on entry to S_START
  - bit-index counter is 3 bits

## Timing
- Reset values (asynchronous, immediate):
  - `midi_tx` = 1, `msg_ready` = 1, `busy` = 0, `led` = 0, `err_status` = 0
  - `last_status` = 0x00; both FSMs idle
- Reset asserted mid-frame:
  - line returns high at once
  - the partial message is discarded; no resumption after release
- Latency and bit timing:
  - accept at edge N → `midi_tx` low from edge N+1
  - every bit lasts exactly BAUD_DIV cycles
- Bytes within a message are back-to-back. The next start bit begins immediately after the stop bit period, with no idle gap.
- Message duration = 10 × BAUD_DIV × bytes_sent. `busy` is high for exactly that many cycles, starting at N+1.
- `msg_ready` returns high on the cycle after the final stop bit period ends. A new message accepted then starts the next frame with no extra idle bit.
- `err_status` is high for the single cycle following the rejected accept. `msg_ready` stays high throughout.
- A `msg_valid` held while busy is not accepted. Inputs may change freely while `msg_ready` = 0.

## Structure
- Package `midi_pkg` holds:
  - status nibble constants (NOTE_OFF 0x8 … PITCH_BEND 0xE, SYSTEM 0xF)
  - `function msg_len(status) → 2'b`
  - `function is_channel_voice(status)`
- Sub-module `midi_uart_tx`:
  - parameter BAUD_DIV
  - byte in with valid/ready
  - owns the baud counter, bit counter and the `midi_tx` register
  - must accept its next byte during its stop bit so bytes run back-to-back
- `midi_msg_tx` owns message length, running status, sequencing and the error pulse.

## Test plan
All scenarios use BAUD_DIV = 4.
- Reset then idle 50 cycles:
  - `midi_tx` stays 1, `msg_ready` = 1, `busy` = 0
- Send 0x90/0x3C/0x64:
  - 30 bit periods = 120 cycles
  - bytes decode (LSB first, start 0, stop 1) to 0x90, 0x3C, 0x64
  - `busy` high exactly 120 cycles; `msg_ready` high at cycle 121
- Send 0x90/0x3C/0x64, then 0x90/0x40/0x00:
  - RUNNING_STATUS = 1: second message is 2 bytes (0x40, 0x00), 80 cycles
  - RUNNING_STATUS = 0: second message is 3 bytes
- Sequence 0xC5/0x07, then 0xF8, then 0xC5/0x07:
  - 0xC5 + 0x07, then 0xF8 alone, then only 0x07 (real-time keeps running status)
  - inserting 0xF2/0x01/0x02 instead of 0xF8 forces 0xC5 to be resent
- Offer status 0x45:
  - one-cycle `err_status` pulse
  - `midi_tx` stays 1; next valid message is transmitted normally
- Assert `rst` during the data bits of byte 2:
  - `midi_tx` goes 1 immediately
  - after release, `msg_ready` = 1 and 0x90/0x3C/0x64 is sent in full, including status
